key_conditioner: RTL and testbench

- Conditions the raw active-low DE2-115 push buttons (KEY) into clean, clock-synchronous control signals for the eLC-3 datapath.
- Its outputs drive register Load/Reset strobes and, later, the single-step/run controls.
- Per key it provides:
  - a two-flop synchronizer,
  - a counter-based debouncer,
  - one-cycle press and release pulses,
  - an optional auto-repeat state machine.

---
 rtl/key_conditioner.sv | 152 +++++++++++++++
 tb/tb_key_conditioner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key two-flop synchronizer, counter debouncer,
// registered press/release strobes and optional auto-repeat.
module key_conditioner #(
   parameter int                N_KEYS          = 4,
   parameter int                DEBOUNCE_CYCLES = 1000000,
   parameter int                REPEAT_DELAY    = 25000000,
   parameter int                REPEAT_PERIOD   = 5000000,
   parameter logic [N_KEYS-1:0] REPEAT_MASK     = {N_KEYS{1'b0}}
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [N_KEYS-1:0] Key_N,
   output logic [N_KEYS-1:0] Level,
   output logic [N_KEYS-1:0] Press,
   output logic [N_KEYS-1:0] Release
);

   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int TMR_W   = $clog2(REP_MAX) + 1;

   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
   localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } rep_state_t;

   logic [N_KEYS-1:0] sync1_r;
   logic [N_KEYS-1:0] sync2_r;
   logic [N_KEYS-1:0] pressed_s;

   // Two-flop synchronizer; reset forces the released (high) level.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1_r <= {N_KEYS{1'b1}};
         sync2_r <= {N_KEYS{1'b1}};
      end else begin
         sync1_r <= Key_N;
         sync2_r <= sync1_r;
      end
   end

   assign pressed_s = ~sync2_r;

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      logic [DEB_W-1:0] deb_cnt_r;
      logic [DEB_W-1:0] deb_cnt_next_s;
      logic             level_r;
      logic             level_next_s;
      logic             press_r;
      logic             release_r;
      logic             rise_s;
      logic             fall_s;
      logic             rep_pulse_s;
      rep_state_t       state_r;
      rep_state_t       state_next_s;
      logic [TMR_W-1:0] timer_r;
      logic [TMR_W-1:0] timer_next_s;

      // Debounce: a level change is accepted only after an unbroken run of mismatches.
      always_comb begin
         deb_cnt_next_s = deb_cnt_r;
         level_next_s   = level_r;
         rise_s         = 1'b0;
         fall_s         = 1'b0;
         if (pressed_s[i] != level_r) begin
            if (deb_cnt_r == DEB_LAST) begin
               deb_cnt_next_s = {DEB_W{1'b0}};
               level_next_s   = pressed_s[i];
               rise_s         = pressed_s[i];
               fall_s         = ~pressed_s[i];
            end else begin
               deb_cnt_next_s = deb_cnt_r + DEB_W'(1);
            end
         end else begin
            deb_cnt_next_s = {DEB_W{1'b0}};
         end
      end

      // Auto-repeat next state; an accepted release wins over a due repeat pulse.
      always_comb begin
         state_next_s = state_r;
         timer_next_s = timer_r;
         rep_pulse_s  = 1'b0;
         if (fall_s) begin
            state_next_s = IDLE;
            timer_next_s = {TMR_W{1'b0}};
         end else begin
            case (state_r)
               IDLE: begin
                  if (rise_s && REPEAT_MASK[i]) begin
                     state_next_s = DELAY;
                     timer_next_s = {TMR_W{1'b0}};
                  end else begin
                     state_next_s = IDLE;
                     timer_next_s = {TMR_W{1'b0}};
                  end
               end
               DELAY: begin
                  if (timer_r == DELAY_LAST) begin
                     rep_pulse_s  = 1'b1;
                     state_next_s = REPEAT;
                     timer_next_s = {TMR_W{1'b0}};
                  end else begin
                     timer_next_s = timer_r + TMR_W'(1);
                  end
               end
               REPEAT: begin
                  if (timer_r == PERIOD_LAST) begin
                     rep_pulse_s  = 1'b1;
                     timer_next_s = {TMR_W{1'b0}};
                  end else begin
                     timer_next_s = timer_r + TMR_W'(1);
                  end
               end
               default: begin
                  state_next_s = IDLE;
                  timer_next_s = {TMR_W{1'b0}};
               end
            endcase
         end
      end

      // Per-key state and registered output strobes.
      always_ff @(posedge Clk) begin
         if (Reset) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
            state_r   <= IDLE;
            timer_r   <= {TMR_W{1'b0}};
         end else begin
            deb_cnt_r <= deb_cnt_next_s;
            level_r   <= level_next_s;
            press_r   <= rise_s | rep_pulse_s;
            release_r <= fall_s;
            state_r   <= state_next_s;
            timer_r   <= timer_next_s;
         end
      end

      assign Level[i]   = level_r;
      assign Press[i]   = press_r;
      assign Release[i] = release_r;
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat parameters.
module tb_key_conditioner;

   logic       Clk;
   logic       Reset;
   logic [3:0] Key_N;
   logic [3:0] Level;
   logic [3:0] Press;
   logic [3:0] Release;

   int n_cmp;
   int n_bad;
   int press_cnt[4];
   int rel_cnt[4];
   int both_cnt;

   key_conditioner #(
      .N_KEYS          (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3),
      .REPEAT_MASK     (4'b0100)
   ) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Key_N   (Key_N),
      .Level   (Level),
      .Press   (Press),
      .Release (Release)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Pulse counters: at each rising edge the pre-update outputs hold last cycle's value.
   always @(posedge Clk) begin
      for (int i = 0; i < 4; i++) begin
         press_cnt[i] += int'(Press[i]);
         rel_cnt[i]   += int'(Release[i]);
         if (Press[i] && Release[i]) both_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge Clk);
   endtask

   task automatic clr_counts();
      for (int i = 0; i < 4; i++) begin
         press_cnt[i] = 0;
         rel_cnt[i]   = 0;
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      both_cnt = 0;
      clr_counts();
      Reset = 1'b1;
      Key_N = 4'hF;
      tick(3);
      check("rst_level", 32'(Level), 32'h0);
      check("rst_press", 32'(Press), 32'h0);
      check("rst_release", 32'(Release), 32'h0);
      Reset = 1'b0;
      tick(3);

      // Clean press and release on key 0
      clr_counts();
      Key_N[0] = 1'b0;
      tick(5);
      check("k0_pre_level", 32'(Level), 32'h0);
      tick(1);
      check("k0_level", 32'(Level), 32'h1);
      check("k0_press", 32'(Press), 32'h1);
      tick(1);
      check("k0_press_end", 32'(Press), 32'h0);
      tick(13);
      check("k0_press_cnt", 32'(press_cnt[0]), 32'd1);
      Key_N[0] = 1'b1;
      tick(5);
      check("k0_rel_pre", 32'(Level), 32'h1);
      tick(1);
      check("k0_rel_level", 32'(Level), 32'h0);
      check("k0_release", 32'(Release), 32'h1);
      tick(1);
      check("k0_release_end", 32'(Release), 32'h0);
      tick(4);
      check("k0_rel_cnt", 32'(rel_cnt[0]), 32'd1);

      // Bouncing key 1, then a clean settle
      clr_counts();
      for (int k = 0; k < 10; k++) begin
         Key_N[1] = (k % 2 == 1);
         tick(2);
         check("k1_bounce_level", 32'(Level), 32'h0);
      end
      check("k1_bounce_press", 32'(press_cnt[1]), 32'd0);
      Key_N[1] = 1'b0;
      tick(5);
      check("k1_settle_pre", 32'(Level), 32'h0);
      tick(1);
      check("k1_settle_level", 32'(Level), 32'h2);
      check("k1_settle_press", 32'(Press), 32'h2);
      Key_N[1] = 1'b1;
      tick(10);
      check("k1_press_cnt", 32'(press_cnt[1]), 32'd1);

      // Three-cycle glitch on key 3 must be rejected
      clr_counts();
      Key_N[3] = 1'b0;
      tick(3);
      Key_N[3] = 1'b1;
      tick(15);
      check("k3_glitch_level", 32'(Level), 32'h0);
      check("k3_glitch_press", 32'(press_cnt[3]), 32'd0);
      check("k3_glitch_rel", 32'(rel_cnt[3]), 32'd0);

      // Auto-repeat on key 2, key 0 held alongside without repeat
      clr_counts();
      Key_N = 4'b1010;
      tick(6);
      check("rep_level", 32'(Level), 32'h5);
      check("rep_press_e", 32'(Press), 32'h5);
      tick(9);
      check("rep_e9", 32'(Press), 32'h0);
      tick(1);
      check("rep_e10", 32'(Press), 32'h4);
      tick(1);
      check("rep_e11", 32'(Press), 32'h0);
      tick(2);
      check("rep_e13", 32'(Press), 32'h4);
      tick(3);
      check("rep_e16", 32'(Press), 32'h4);
      tick(3);
      check("rep_e19", 32'(Press), 32'h4);
      tick(12);
      check("rep_e31", 32'(Press), 32'h4);
      Key_N = 4'hF;
      tick(5);
      check("rep_e36_level", 32'(Level), 32'h5);
      tick(1);
      check("rep_e37_level", 32'(Level), 32'h0);
      check("rep_e37_release", 32'(Release), 32'h5);
      check("rep_e37_press", 32'(Press), 32'h0);
      tick(10);
      check("rep_k2_press_cnt", 32'(press_cnt[2]), 32'd10);
      check("rep_k2_rel_cnt", 32'(rel_cnt[2]), 32'd1);
      check("rep_k0_press_cnt", 32'(press_cnt[0]), 32'd1);

      // Reset while key 2 is repeating
      clr_counts();
      Key_N[2] = 1'b0;
      tick(6);
      check("rst_hold_level", 32'(Level), 32'h4);
      tick(12);
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      check("rst_mid_level", 32'(Level), 32'h0);
      check("rst_mid_press", 32'(Press), 32'h0);
      check("rst_mid_release", 32'(Release), 32'h0);
      tick(5);
      check("rst_after_pre", 32'(Level), 32'h0);
      tick(1);
      check("rst_after_level", 32'(Level), 32'h4);
      check("rst_after_press", 32'(Press), 32'h4);
      check("rst_no_release", 32'(rel_cnt[2]), 32'd0);
      Key_N[2] = 1'b1;
      tick(10);

      // All keys pressed together
      clr_counts();
      Key_N = 4'h0;
      tick(5);
      check("all_pre", 32'(Level), 32'h0);
      tick(1);
      check("all_level", 32'(Level), 32'hF);
      check("all_press", 32'(Press), 32'hF);
      tick(1);
      check("all_press_end", 32'(Press), 32'h0);
      tick(2);
      for (int i = 0; i < 4; i++) check("all_press_cnt", 32'(press_cnt[i]), 32'd1);
      Key_N = 4'hF;
      tick(10);
      check("all_rel_cnt", 32'(rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]), 32'd4);
      check("never_both", 32'(both_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
